// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Multi-cycle EX-stage ALU. It keeps the 4-bit ALU control encoding of the
//   original single-cycle datapath ALU. It adds an iterative multiply, an
//   unsigned divide/remainder, status flags and valid/ready handshakes on both
//   the input and output sides.
//
//   ADD/SUB/AND/OR and unsupported codes complete in one cycle. MUL, DIVU and
//   REMU run WIDTH iterations in BUSY. The result and flags are registered when
//   DONE is entered and stay stable until the consumer takes them.
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous active-high reset
//   valid_i    in   operands/op valid
//   ready_o    out  op can be accepted this cycle (combinational on ready_i)
//   data1_i    in   operand A (WIDTH)
//   data2_i    in   operand B (WIDTH)
//   ALUCtrl_i  in   operation code (4)
//   valid_o    out  result valid, held until accepted
//   ready_i    in   consumer accepts the result
//   data_o     out  result (WIDTH)
//   zero_o     out  data_o == 0
//   ovf_o      out  signed overflow of ADD/SUB
//   div0_o     out  DIVU/REMU with a zero divisor
//   illegal_o  out  unsupported ALUCtrl_i
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             div0_o,
    output logic             illegal_o
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b1111;
    localparam logic [3:0] OP_DIVU = 4'b1000;
    localparam logic [3:0] OP_REMU = 4'b1001;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    // a_q: multiplicand (shifted left) or divisor (static).
    // q_q: multiplier (shifted right) or dividend/quotient shift register.
    // acc_q: product accumulator or partial remainder.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             div0_q, div0_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] sc_res;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        q_d       = q_q;
        acc_d     = acc_q;
        data_d    = data_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        div0_d    = div0_q;
        illegal_d = illegal_q;
        sc_res    = '0;

        ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
        valid_o = (state_q == DONE);
        accept  = valid_i && ready_o;

        // One shift-add multiply step.
        mul_sum = acc_q + (q_q[0] ? a_q : '0);

        // One restoring-divide step. A non-negative trial difference yields a
        // quotient bit of 1. A zero divisor therefore yields all ones and leaves
        // the dividend as the remainder without special handling.
        rem_shift = {acc_q, q_q[WIDTH-1]};
        div_diff  = rem_shift - {1'b0, a_q};
        div_rem   = div_diff[WIDTH] ? rem_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_quo   = {q_q[WIDTH-2:0], ~div_diff[WIDTH]};

        unique case (state_q)
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_sum;
                    a_d   = a_q << 1;
                    q_d   = q_q >> 1;
                end else begin
                    acc_d = div_rem;
                    q_d   = div_quo;
                end
                if (cnt_q == LAST_ITER) begin
                    state_d   = DONE;
                    data_d    = (op_q == OP_MUL)  ? mul_sum :
                                (op_q == OP_DIVU) ? div_quo : div_rem;
                    zero_d    = (data_d == '0);
                    ovf_d     = 1'b0;
                    div0_d    = (op_q != OP_MUL) && (a_q == '0);
                    illegal_d = 1'b0;
                end
            end
            default: begin
                if (accept) begin
                    op_d = ALUCtrl_i;
                    if (is_multi(ALUCtrl_i)) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        acc_d   = '0;
                        if (ALUCtrl_i == OP_MUL) begin
                            a_d = data1_i;
                            q_d = data2_i;
                        end else begin
                            a_d = data2_i;
                            q_d = data1_i;
                        end
                    end else begin
                        state_d   = DONE;
                        ovf_d     = 1'b0;
                        div0_d    = 1'b0;
                        illegal_d = 1'b0;
                        case (ALUCtrl_i)
                            OP_ADD: begin
                                sc_res = data1_i + data2_i;
                                ovf_d  = add_ovf(data1_i, data2_i, sc_res);
                            end
                            OP_SUB: begin
                                sc_res = data1_i - data2_i;
                                ovf_d  = sub_ovf(data1_i, data2_i, sc_res);
                            end
                            OP_AND:  sc_res = data1_i & data2_i;
                            OP_OR:   sc_res = data1_i | data2_i;
                            default: illegal_d = 1'b1;
                        endcase
                        data_d = sc_res;
                        zero_d = (sc_res == '0);
                    end
                end else if ((state_q == DONE) && ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // The datapath registers are reset as well, so the outputs are 0 out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            div0_q    <= div0_d;
            illegal_q <= illegal_d;
        end
    end

    assign data_o    = data_q;
    assign zero_o    = zero_q;
    assign ovf_o     = ovf_q;
    assign div0_o    = div0_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic [3:0]   ALUCtrl_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic         zero_o;
    logic         ovf_o;
    logic         div0_o;
    logic         illegal_o;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .ALUCtrl_i (ALUCtrl_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .ovf_o     (ovf_o),
        .div0_o    (div0_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present an op for one edge. The caller ensures ready_o is high.
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        valid_i   = 1'b1;
        tick();
        valid_i   = 1'b0;
        data1_i   = 'x;
        data2_i   = 'x;
    endtask

    // Count the edges after acceptance until valid_o rises. The count is bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic go_idle();
        ready_i = 1'b1;
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        ALUCtrl_i = 4'b0000;
        data1_i = '0;
        data2_i = '0;
        tick();
        tick();
        checks++;
        if ({valid_o, zero_o, ovf_o, div0_o, illegal_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {valid_o, zero_o, ovf_o, div0_o, illegal_o});
        end
        checks++;
        if (data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", data_o);
        end
        #3 rst_i = 1'b0;
        tick();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
        end
    endtask

    task automatic test_illegal();
        int n;
        ready_i = 1'b1;
        start_op(4'b0101, 32'h5, 32'h6);
        wait_valid(n);
        checks++;
        if (n !== 0 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL illegal_latency: got %0d edges expected 0", n);
        end
        checks++;
        if (data_o !== '0 || illegal_o !== 1'b1 || zero_o !== 1'b1 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_result: got data=%h ill=%b z=%b ovf=%b expected 0 1 1 0", data_o, illegal_o, zero_o, ovf_o);
        end
        go_idle();
    endtask

    task automatic test_add();
        int n;
        ready_i = 1'b1;
        start_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_valid(n);
        checks++;
        if (n !== 0 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL add_latency: got %0d edges expected 0", n);
        end
        checks++;
        if (data_o !== 32'h8000_0000 || ovf_o !== 1'b1 || zero_o !== 1'b0 || illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got data=%h ovf=%b z=%b ill=%b expected 80000000 1 0 0", data_o, ovf_o, zero_o, illegal_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL add_consume: got valid=%b ready=%b expected 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        start_op(4'b0110, 32'd5, 32'd5);
        checks++;
        if (valid_o !== 1'b1 || data_o !== '0 || zero_o !== 1'b1 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL sub_result: got v=%b data=%h z=%b ovf=%b expected 1 0 1 0", valid_o, data_o, zero_o, ovf_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b expected 1", ready_o);
        end
        // Next op offered in the DONE cycle.
        start_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'hF000_F000 || zero_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_and: got v=%b data=%h z=%b expected 1 f000f000 0", valid_o, data_o, zero_o);
        end
        go_idle();
    endtask

    task automatic test_mul();
        int n;
        int busy_bad;
        ready_i = 1'b1;
        busy_bad = 0;
        start_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (!valid_o && n < 200) begin
            if (ready_o !== 1'b0) busy_bad++;
            // Offer a competing ADD on every other cycle. It must be ignored.
            valid_i   = n[0];
            ALUCtrl_i = 4'b0010;
            data1_i   = 32'h1234;
            data2_i   = 32'h1;
            tick();
            n++;
        end
        valid_i = 1'b0;
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL mul_busy_ready: got %0d cycles with ready_o high expected 0", busy_bad);
        end
        checks++;
        if (n !== 32 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mul_latency: got %0d edges expected 32", n);
        end
        checks++;
        if (data_o !== 32'h0000_0001 || ovf_o !== 1'b0 || zero_o !== 1'b0 || div0_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: got data=%h ovf=%b z=%b d0=%b expected 00000001 0 0 0", data_o, ovf_o, zero_o, div0_o);
        end
        go_idle();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_ignored_op: got valid=%b data=%h expected valid 0", valid_o, data_o);
        end
    endtask

    task automatic test_div();
        logic [3:0]   ops [4] = '{4'b1000, 4'b1001, 4'b1000, 4'b1001};
        logic [W-1:0] as  [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
        logic [W-1:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
        logic [W-1:0] exp [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
        logic         ed0 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int n;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(ops[i], as[i], bs[i]);
            wait_valid(n);
            checks++;
            if (n !== 32 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d edges expected 32", i, n);
            end
            checks++;
            if (data_o !== exp[i] || div0_o !== ed0[i] || ovf_o !== 1'b0) begin
                errors++;
                $display("FAIL div_result[%0d]: got data=%h d0=%b ovf=%b expected %h %b 0", i, data_o, div0_o, ovf_o, exp[i], ed0[i]);
            end
            go_idle();
        end
    endtask

    task automatic test_backpressure();
        int bad;
        ready_i = 1'b0;
        bad = 0;
        start_op(4'b0001, 32'h1, 32'h2);
        for (int i = 0; i < 5; i++) begin
            if (valid_o !== 1'b1 || data_o !== 32'h3 || ready_o !== 1'b0 || zero_o !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d bad cycles expected 0 (data=%h)", bad, data_o);
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_ready_path: got %b expected 1", ready_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: got valid=%b ready=%b expected 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset_mid_mul();
        int n;
        ready_i = 1'b1;
        start_op(4'b1111, 32'd1000, 32'd77);
        for (int i = 0; i < 10; i++) tick();
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || {zero_o, ovf_o, div0_o, illegal_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got v=%b data=%h flags=%b expected 0 0 0000", valid_o, data_o, {zero_o, ovf_o, div0_o, illegal_o});
        end
        #1 rst_i = 1'b0;
        tick();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: got ready=%b valid=%b expected 1 0", ready_o, valid_o);
        end
        start_op(4'b0010, 32'd2, 32'd3);
        wait_valid(n);
        checks++;
        if (n !== 0 || data_o !== 32'd5 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_add: got n=%0d data=%h ovf=%b expected 0 5 0", n, data_o, ovf_o);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_add();
        test_back_to_back();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
